log2_db_avg: RTL

//  Downstream consumer of the pipelined log2 stage. Block-averages 2**AVG_LOG2 signed

---
 rtl/log2_db_avg.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/log2_db_avg.sv
// log2_db_avg
//   Block-averages 2**AVG_LOG2 signed fixed-point log2 samples, scales the
//   mean to decibels (x 10*log10(2)), rounds half up, saturates, and queues
//   the results in a show-ahead FIFO behind a valid/ready output.
//   The input side never stalls. A finished result that finds the FIFO full
//   is dropped and flagged on overrun_o.
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   log2_i     signed log2 sample, IN_POINT fractional bits
//   valid_i    log2_i valid this cycle
//   flush_i    discard the partially accumulated block
//   db_o       signed mean level in dB, OUT_POINT fractional bits (FIFO head)
//   valid_o    db_o valid (FIFO not empty)
//   ready_i    consumer accepts db_o when valid_o & ready_i
//   overrun_o  1-cycle pulse: finished result dropped because the FIFO was full
module log2_db_avg #(
    parameter int IN_WIDTH   = 21,
    parameter int IN_POINT   = 15,
    parameter int AVG_LOG2   = 4,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_POINT  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [IN_WIDTH-1:0]  log2_i,
    input  logic                        valid_i,
    input  logic                        flush_i,
    output logic signed [OUT_WIDTH-1:0] db_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        overrun_o
);

    localparam int ACC_W  = IN_WIDTH + AVG_LOG2;
    localparam int K_W    = 19;  // 18-bit unsigned constant plus a zero sign bit
    localparam int PROD_W = IN_WIDTH + K_W;
    localparam int SH     = IN_POINT + 16 - OUT_POINT;
    localparam int RW     = PROD_W + 1 - SH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    // 10*log10(2) in Q2.16
    localparam logic signed [K_W-1:0]    K      = 19'sd197283;
    localparam logic signed [PROD_W:0]   HALF   = {{(PROD_W-SH+1){1'b0}}, 1'b1, {(SH-1){1'b0}}};
    localparam logic signed [RW-1:0]     SAT_HI = RW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0]     SAT_LO = ~SAT_HI;
    localparam logic [AVG_LOG2-1:0]      CNT_MAX = '1;
    localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Round half up at bit SH, then clamp into the OUT_WIDTH signed range.
    // The extra top bit keeps the rounding add from wrapping.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W:0] s;
        logic signed [RW-1:0]   r;
        s = {p[PROD_W-1], p} + HALF;
        r = RW'(s >>> SH);
        if (r > SAT_HI)
            return OUT_WIDTH'(SAT_HI);
        else if (r < SAT_LO)
            return OUT_WIDTH'(SAT_LO);
        else
            return OUT_WIDTH'(r);
    endfunction

    logic signed [ACC_W-1:0]     acc;
    logic [AVG_LOG2-1:0]         cnt;
    logic signed [ACC_W-1:0]     sample_ext;
    logic signed [ACC_W-1:0]     block_sum;

    logic signed [IN_WIDTH-1:0]  mean_p1;
    logic                        vld_p1;
    logic signed [PROD_W-1:0]    prod_p2;
    logic                        vld_p2;
    logic signed [OUT_WIDTH-1:0] res_p3;
    logic                        vld_p3;

    assign sample_ext = {{AVG_LOG2{log2_i[IN_WIDTH-1]}}, log2_i};
    assign block_sum  = acc + sample_ext;

    // ---- stage 1: accumulate, emit floor mean on the last sample of a block
    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (flush_i) begin
                // A sample arriving with flush starts the new block.
                acc <= valid_i ? sample_ext : '0;
                cnt <= valid_i ? AVG_LOG2'(1) : '0;
            end else if (valid_i) begin
                if (cnt == CNT_MAX) begin
                    acc    <= '0;
                    cnt    <= '0;
                    vld_p1 <= 1'b1;
                end else begin
                    acc <= block_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (valid_i && !flush_i && cnt == CNT_MAX)
            mean_p1 <= IN_WIDTH'(block_sum >>> AVG_LOG2);
    end

    // ---- stage 2: scale to dB
    // ---- stage 3: round and saturate
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge clock) begin
        prod_p2 <= PROD_W'(mean_p1) * PROD_W'(K);
        res_p3  <= round_sat(prod_p2);
    end

    // ---- result FIFO (show-ahead)
    logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            count;
    logic                        full;
    logic                        pop;
    logic                        push;

    assign valid_o = (count != '0);
    assign full    = (count == FULL_CNT);
    assign pop     = valid_o & ready_i;
    // A pop frees the slot in the same cycle, so full+pop still accepts.
    assign push    = vld_p3 & (~full | pop);
    assign db_o    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_o <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            overrun_o <= vld_p3 & full & ~pop;
            if (push) begin
                mem[wr_ptr] <= res_p3;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
